positron_layer_serializer: RTL and testbench
============================================

// Module: positron_layer_serializer
// PURPOSE
// - Transmit side of the positron rtr/rts/sow/eow stream. Collects the one-posit-per-window result of
//   NB_POSITRONS parallel positrons, then serializes it as a single framed window for the next layer.
// - Sits between layer k's positron master ports and layer k+1's shared slave inputs (posit_i/sow_i/eow_i).
// PARAMETERS
// - POSIT_WIDTH   4   width of one posit word
// - NB_POSITRONS  16  number of upstream lanes = words per emitted window (>=2)
// PORTS
// - clk      in   1                       clock
// - rst_n    in   1                       reset, asynchronous, active-low
// - rtr_o    out  NB_POSITRONS            per-lane ready-to-receive (to positron rtr_i)
// - rts_i    in   NB_POSITRONS            per-lane ready-to-send (positron rts_o, already gated by eow)
// - eow_i    in   NB_POSITRONS            per-lane end-of-window (capture qualifier)
// - posit_i  in   NB_POSITRONS*POSIT_WIDTH lane i at [i*POSIT_WIDTH +: POSIT_WIDTH]
// - rtr_i    in   1                       downstream ready-to-receive
// - rts_o    out  1                       output word valid
// - sow_o    out  1                       high with word 0 of window
// - eow_o    out  1                       high with word NB_POSITRONS-1
// - posit_o  out  POSIT_WIDTH             output word
// - busy_o   out  1                       high in SEND state
// BEHAVIOUR
// - Reset: state=COLLECT, lane_full=0, idx=0; rtr_o=all 1, rts_o=sow_o=eow_o=busy_o=0, posit_o=0.
// - Lane capture: handshake when rts_i[i]&eow_i[i]&rtr_o[i]; stores word, sets lane_full[i]. rtr_o[i]=~lane_full[i]
//   (COLLECT bank). Lanes capture independently, any order, any cycle; rts_i on a full lane is held off.
// - FSM COLLECT->SEND: at the first edge where registered lane_full is all ones. Last capture in cycle c
//   -> rts_o=1, sow_o=1, posit_o=lane0 in cycle c+2.
// - SEND: posit_o=word[idx], rts_o=1, sow_o=(idx==0), eow_o=(idx==NB_POSITRONS-1). Output transfer
//   = rts_o&rtr_i; idx increments only on transfer; outputs held stable while rtr_i=0.
// - SEND->COLLECT: on transfer with idx==NB_POSITRONS-1; idx wraps to 0, sent bank's lane_full cleared
//   the same edge; rts_o=0 next cycle.
// - Output order always lane 0..NB_POSITRONS-1, independent of capture order.
// - idx width = $clog2(NB_POSITRONS); never exceeds NB_POSITRONS-1.
// - Reset mid-window (either state): all captured data discarded, return to reset values; no partial window
//   is ever emitted after reset.
// CONFIGURATION
// - POSITRON_SER_DOUBLE_BUFFER_EN defined: two banks. rtr_o reflects the collect bank, which stays open
//   during SEND. At SEND->COLLECT, if collect bank already full, banks swap and the FSM stays in SEND
//   (next cycle: rts_o=1, sow_o=1, no bubble). Sent bank cleared on its final transfer.
// - Not defined: single bank; rtr_o=all 0 whenever state=SEND; capture only in COLLECT.
// TESTING
// - N=4,W=4: lanes 0..3 send 4'h1,2,3,4 same cycle c, rtr_i=1 -> c+2..c+5 posit_o=1,2,3,4; sow at 1, eow at 4.
// - Lanes arrive order 3,1,0,2 with values 4'hA,B,C,D on lanes 0..3 -> emitted C? no: emitted lane0..3 = A,B,C,D.
// - rtr_i toggling 1,0,0,1,... during SEND -> each word held while rtr_i=0; exactly 4 transfers, no dup/skip.
// - Lane 2 rts_i held high after capture -> rtr_o[2]=0 until window sent; second value captured after.
// - rst_n pulsed low after 2 of 4 words sent -> rts_o=0, rtr_o=4'hF; next window starts with sow_o, word 0.
// - DOUBLE_BUFFER_EN: second window fully captured during SEND -> its sow follows first eow next cycle.

Source files
------------

// File: rtl/positron_layer_serializer.sv
// Collects one posit per upstream positron lane and replays them as one framed sow/eow window.
// Optional macro POSITRON_SER_DOUBLE_BUFFER_EN adds a second bank so collection continues during SEND.
module positron_layer_serializer #(
  parameter int POSIT_WIDTH  = 4,
  parameter int NB_POSITRONS = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic [NB_POSITRONS-1:0]              rtr_o,
  input  logic [NB_POSITRONS-1:0]              rts_i,
  input  logic [NB_POSITRONS-1:0]              eow_i,
  input  logic [NB_POSITRONS*POSIT_WIDTH-1:0]  posit_i,
  input  logic                                 rtr_i,
  output logic                                 rts_o,
  output logic                                 sow_o,
  output logic                                 eow_o,
  output logic [POSIT_WIDTH-1:0]               posit_o,
  output logic                                 busy_o
);

  localparam int IDX_W = $clog2(NB_POSITRONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITRONS - 1);
`ifdef POSITRON_SER_DOUBLE_BUFFER_EN
  localparam int NB_BANKS = 2;
`else
  localparam int NB_BANKS = 1;
`endif

  typedef enum logic {COLLECT, SEND} state_t;

  state_t                                 state_reg, state_next;
  logic [IDX_W-1:0]                       idx_reg, idx_next;
  logic                                   collect_bank, send_bank;
  logic                                   capture_en, collect_full, clear_send, xfer;
  logic [NB_POSITRONS-1:0]                capture, collect_lanes;
  logic [NB_BANKS-1:0][NB_POSITRONS-1:0]  bank_full;
  logic [POSIT_WIDTH-1:0]                 bank_word [NB_BANKS];
  logic [POSIT_WIDTH-1:0]                 send_word;

`ifdef POSITRON_SER_DOUBLE_BUFFER_EN
  logic swap;
  logic collect_bank_reg;

  // The collect bank never closes; banks trade roles whenever a full bank is handed to SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      collect_bank_reg <= 1'b0;
    else if (swap)
      collect_bank_reg <= ~collect_bank_reg;
  end

  assign collect_bank = collect_bank_reg;
  assign send_bank    = ~collect_bank_reg;
  assign capture_en   = 1'b1;
`else
  assign collect_bank = 1'b0;
  assign send_bank    = 1'b0;
  assign capture_en   = (state_reg == COLLECT);
`endif

  always_comb begin
    collect_lanes = '0;
    send_word     = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      if (1'(b) == collect_bank) collect_lanes = bank_full[b];
      if (1'(b) == send_bank)    send_word     = bank_word[b];
    end
  end

  assign collect_full = &collect_lanes;
  assign rtr_o        = capture_en ? ~collect_lanes : '0;
  assign capture      = rts_i & eow_i & rtr_o;
  assign xfer         = (state_reg == SEND) & rtr_i;

  for (genvar gi = 0; gi < NB_BANKS; gi++) begin : g_bank
    logic [NB_POSITRONS-1:0] full_reg;
    logic [POSIT_WIDTH-1:0]  mem [NB_POSITRONS];

    // Clearing has priority; it only ever targets the bank that is not collecting.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        full_reg <= '0;
      else if (clear_send && (send_bank == 1'(gi)))
        full_reg <= '0;
      else if (collect_bank == 1'(gi))
        full_reg <= full_reg | capture;
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < NB_POSITRONS; i++) begin
        if ((collect_bank == 1'(gi)) && capture[i])
          mem[i] <= posit_i[i*POSIT_WIDTH +: POSIT_WIDTH];
      end
    end

    assign bank_full[gi] = full_reg;
    assign bank_word[gi] = mem[idx_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    clear_send = 1'b0;
`ifdef POSITRON_SER_DOUBLE_BUFFER_EN
    swap       = 1'b0;
`endif
    case (state_reg)
      COLLECT: begin
        if (collect_full) begin
          state_next = SEND;
`ifdef POSITRON_SER_DOUBLE_BUFFER_EN
          swap       = 1'b1;
`endif
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            clear_send = 1'b1;
`ifdef POSITRON_SER_DOUBLE_BUFFER_EN
            if (collect_full)
              swap = 1'b1;
            else
              state_next = COLLECT;
`else
            state_next = COLLECT;
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  assign rts_o   = (state_reg == SEND);
  assign busy_o  = (state_reg == SEND);
  assign sow_o   = (state_reg == SEND) && (idx_reg == '0);
  assign eow_o   = (state_reg == SEND) && (idx_reg == LAST_IDX);
  assign posit_o = (state_reg == SEND) ? send_word : '0;

endmodule

// File: tb/tb_positron_layer_serializer.sv
// Scoreboard bench for positron_layer_serializer (N=4, W=4): stimulus queues expected words,
// a negedge monitor pops and compares on every output transfer.
module tb_positron_layer_serializer;

  localparam int N = 4;
  localparam int W = 4;
`ifdef POSITRON_SER_DOUBLE_BUFFER_EN
  localparam logic [N-1:0] SEND_RTR   = 4'hF;
  localparam int           REOPEN_CYC = 1;
`else
  localparam logic [N-1:0] SEND_RTR   = 4'h0;
  localparam int           REOPEN_CYC = 5;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   rtr_o;
  logic [N-1:0]   rts_i = '0;
  logic [N-1:0]   eow_i = '0;
  logic [N*W-1:0] posit_i = '0;
  logic           rtr_i = 1'b1;
  logic           rts_o, sow_o, eow_o, busy_o;
  logic [W-1:0]   posit_o;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [5:0] exp_q [$];
  logic [5:0] exp_word;
  logic       stall_prev = 1'b0;
  logic [5:0] stall_val;

  positron_layer_serializer #(.POSIT_WIDTH(W), .NB_POSITRONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o), .rts_i(rts_i), .eow_i(eow_i),
    .posit_i(posit_i), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o),
    .eow_o(eow_o), .posit_o(posit_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every output transfer pops the next expected {sow,eow,posit}.
  always @(negedge clk) begin
    if (rst_n && rts_o && rtr_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h required=none", posit_o);
      end else begin
        exp_word = exp_q.pop_front();
        $display("xfer sow=%0b eow=%0b posit=%0h", sow_o, eow_o, posit_o);
        check("out_word", {26'd0, sow_o, eow_o, posit_o}, {26'd0, exp_word});
        pops++;
      end
    end
  end

  // A stalled word must still be presented, unchanged, on the following cycle.
  always @(negedge clk) begin
    if (rst_n && stall_prev)
      check("hold_while_stalled", {25'd0, rts_o, sow_o, eow_o, posit_o}, {25'd0, 1'b1, stall_val});
    stall_prev = rst_n && rts_o && !rtr_i;
    stall_val  = {sow_o, eow_o, posit_o};
  end

  task automatic push_window(input logic [W-1:0] w0, w1, w2, w3);
    exp_q.push_back({2'b10, w0});
    exp_q.push_back({2'b00, w1});
    exp_q.push_back({2'b00, w2});
    exp_q.push_back({2'b01, w3});
  endtask

  // Present lanes in mask for one cycle; returns 1ns after the capturing edge.
  task automatic drive_lanes(input logic [N-1:0] mask, input logic [N*W-1:0] vals);
    rts_i   = mask;
    eow_i   = mask;
    posit_i = vals;
    @(posedge clk); #1;
    rts_i = '0;
    eow_i = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rts_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rts", rts_o, 0);
    check("rst_rtr", rtr_o, 4'hF);
    check("rst_busy", busy_o, 0);
    check("rst_sow_eow", {sow_o, eow_o}, 0);
    check("rst_posit", posit_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All lanes in the same cycle c; first word in c+2
    push_window(4'h1, 4'h2, 4'h3, 4'h4);
    drive_lanes(4'hF, 16'h4321);
    @(negedge clk);
    check("c1_rts", rts_o, 0);
    check("c1_rtr", rtr_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("c2_first_word", {rts_o, sow_o, busy_o, posit_o}, {3'b111, 4'h1});
    check("send_rtr", rtr_o, SEND_RTR);
    wait_idle("drain_same_cycle");

    // Out-of-order arrival 3,1,0,2; emitted in lane order
    push_window(4'hA, 4'hB, 4'hC, 4'hD);
    drive_lanes(4'b1000, 16'hD000);
    drive_lanes(4'b0010, 16'h00B0);
    @(negedge clk);
    check("partial_rtr", rtr_o, 4'b0101);
    @(posedge clk); #1;
    drive_lanes(4'b0001, 16'h000A);
    drive_lanes(4'b0100, 16'h0C00);
    wait_idle("drain_out_of_order");

    // Downstream backpressure 1,0,0,1,...
    push_window(4'h5, 4'h6, 4'h7, 4'h8);
    drive_lanes(4'hF, 16'h8765);
    n = 0;
    while ((exp_q.size() != 0 || rts_o) && n < 100) begin
      rtr_i = (n % 4 == 0) || (n % 4 == 3);
      @(posedge clk); #1;
      n++;
    end
    rtr_i = 1'b1;
    check("drain_backpressure", exp_q.size(), 0);

    // Lane 2 keeps requesting after capture: held off until its bank reopens
    push_window(4'h9, 4'hA, 4'hB, 4'hC);
    push_window(4'h1, 4'h2, 4'hE, 4'h3);
    rts_i = 4'hF; eow_i = 4'hF; posit_i = 16'hCBA9;
    @(posedge clk); #1;
    rts_i = 4'b0100; eow_i = 4'b0100; posit_i = 16'h0E00;
    @(negedge clk);
    check("lane2_held", rtr_o, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rtr_o[2] && n < 50);
    check("lane2_reopen_cycle", n, REOPEN_CYC);
    @(posedge clk); #1;
    rts_i = '0; eow_i = '0;
    @(negedge clk);
    check("lane2_second_capture", rtr_o, 4'b1011);
    @(posedge clk); #1;
    drive_lanes(4'b1011, 16'h3021);
    wait_idle("drain_lane2");

    // Reset after two words of a window
    push_window(4'h1, 4'h2, 4'h3, 4'h4);
    base = pops;
    drive_lanes(4'hF, 16'h4321);
    n = 0;
    while (pops < base + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("two_sent", pops - base, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rts", rts_o, 0);
    check("midrst_rtr", rtr_o, 4'hF);
    check("midrst_busy_sow", {busy_o, sow_o, posit_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {rts_o, rtr_o}, {1'b0, 4'hF});
    @(posedge clk); #1;
    push_window(4'h7, 4'h8, 4'h9, 4'hA);
    drive_lanes(4'hF, 16'hA987);
    wait_idle("drain_after_reset");

`ifdef POSITRON_SER_DOUBLE_BUFFER_EN
    // Second window captured during SEND follows with no bubble
    push_window(4'h1, 4'h2, 4'h3, 4'h4);
    push_window(4'h5, 4'h6, 4'h7, 4'h8);
    drive_lanes(4'hF, 16'h4321);
    @(posedge clk); #1;
    drive_lanes(4'hF, 16'h8765);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rts_o && eow_o) && n < 50);
    @(negedge clk);
    check("db_back_to_back", {rts_o, sow_o, posit_o}, {2'b11, 4'h5});
    wait_idle("drain_double_buffer");
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
